mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 111 +++++++++++
 tb/tb_mul_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential 32x32 shift-and-add multiplier (low 32 bits of the product).
// Each add goes through a shared external ALU, so a step only commits on a granted cycle.
module mul_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_out
);

    localparam logic [2:0] ALU_ADD = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  step_q, step_d;
    logic        last_step;

    // Last step when no higher multiplier bits remain or all 32 bits are consumed.
    assign last_step = (mplier_q[31:1] == 31'd0) || (step_q == 5'd31);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            result_q <= 32'd0;
            step_q   <= 5'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        step_d   = step_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d  = 32'd0;
                    step_d = 5'd0;
                    if (src_b != 32'd0) begin
                        mcand_d  = src_a;
                        mplier_d = src_b;
                        state_d  = RUN;
                    end else begin
                        // Zero multiplier: skip the ALU entirely.
                        result_d = 32'd0;
                        state_d  = DONE;
                    end
                end
            end
            RUN: begin
                if (alu_gnt) begin
                    if (mplier_q[0]) begin
                        acc_d = alu_out;
                    end
                    mcand_d  = {mcand_q[30:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[31:1]};
                    step_d   = step_q + 5'd1;
                    if (last_step) begin
                        result_d = acc_d;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign alu_req = (state_q == RUN);
    assign alu_a   = acc_q;
    assign alu_b   = mcand_q;
    assign alu_op  = ALU_ADD;
    assign result  = result_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed-vector bench for mul_seq with a behavioural shared-ALU model.
module tb_mul_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_out;

    int n_vec = 0;
    int n_err = 0;

    mul_seq dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .src_a   (src_a),
        .src_b   (src_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .alu_req (alu_req),
        .alu_gnt (alu_gnt),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_out (alu_out)
    );

    // Shared ALU: only add is meaningful here; anything else returns a marker value.
    assign alu_out = (alu_op == 3'b010) ? (alu_a + alu_b) : 32'hBAD0_BAD0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Run one multiply. gpat bit i is the grant for RUN cycle i (1 beyond bit 31).
    // poke_at >= 0 re-asserts start with src_b=9 during that RUN cycle.
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_run, input int exp_gnt,
                          input logic [31:0] gpat, input int poke_at);
        int          runs;
        int          grants;
        bit          seen;
        bit          prev_gnt;
        logic [31:0] prev_a;
        logic [31:0] prev_b;
        runs = 0; grants = 0; seen = 0; prev_gnt = 1'b1;
        prev_a = 32'd0; prev_b = 32'd0;
        src_a = a; src_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            alu_gnt = (i < 32) ? gpat[i] : 1'b1;
            if (i == poke_at) begin
                start = 1'b1; src_b = 32'd9; src_a = 32'd1000;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1;
            end else begin
                if (i == 0) begin
                    chk({tag, " first alu_a"}, alu_a, 32'd0);
                    chk({tag, " first alu_b"}, alu_b, a);
                    chk({tag, " alu_op"}, {29'd0, alu_op}, 32'd2);
                end
                if (i > 0 && !prev_gnt) begin
                    chk({tag, " hold acc"}, alu_a, prev_a);
                    chk({tag, " hold mcand"}, alu_b, prev_b);
                end
                chk({tag, " busy"}, {31'd0, busy}, 32'd1);
                if (alu_req) begin
                    runs++;
                    if (alu_gnt) grants++;
                end
                prev_gnt = alu_gnt; prev_a = alu_a; prev_b = alu_b;
                tick();
            end
        end
        start = 1'b0;
        alu_gnt = 1'b1;
        if (!seen) begin
            chk({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, " result"}, result, exp_res);
            chk({tag, " run cycles"}, runs, exp_run);
            chk({tag, " grants"}, grants, exp_gnt);
            chk({tag, " busy@done"}, {31'd0, busy}, 32'd1);
            tick();
            chk({tag, " done pulse"}, {31'd0, done}, 32'd0);
            chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
            chk({tag, " result hold"}, result, exp_res);
        end
    endtask

    initial begin
        int done_cnt;
        reset = 1'b0; start = 1'b1; src_a = 32'd5; src_b = 32'd5; alu_gnt = 1'b1;
        tick();
        tick();
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst alu_req", {31'd0, alu_req}, 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        chk("rst alu_op", {29'd0, alu_op}, 32'd2);
        start = 1'b0;
        reset = 1'b1;
        tick();
        chk("idle after rst", {31'd0, busy}, 32'd0);

        do_mul("7x5", 32'd7, 32'd5, 32'd35, 3, 3, 32'hFFFF_FFFF, -1);
        do_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, 32, 32'hFFFF_FFFF, -1);
        do_mul("123x0", 32'd123, 32'd0, 32'd0, 0, 0, 32'hFFFF_FFFF, -1);
        do_mul("3x6 gnt", 32'd3, 32'd6, 32'd18, 5, 3, 32'hFFFF_FFF5, -1);

        // Reset in the middle of 10*15.
        src_a = 32'd10; src_b = 32'd15; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid busy pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid busy", {31'd0, busy}, 32'd0);
        chk("mid alu_req", {31'd0, alu_req}, 32'd0);
        chk("mid result", result, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("mid no done", done_cnt, 32'd0);
        do_mul("2x3", 32'd2, 32'd3, 32'd6, 2, 2, 32'hFFFF_FFFF, -1);

        do_mul("4x4 restart", 32'd4, 32'd4, 32'd16, 3, 3, 32'hFFFF_FFFF, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
